// File: rtl/deci_key_pkg.sv
// ---------------------------------------------------------------------------
// deci_key_pkg
// Shared definitions for the decimal key debouncer front-end and the benches
// that exercise it alongside the decimal-to-binary encoder.
//   - DB_CYCLES_DEFAULT : default number of stable cycles to accept a change
//   - KEY_W             : number of decimal key lines (keys 0..9)
//   - deci_state_t      : debouncer FSM state encoding (3 bits)
//   - onehot10()        : true when exactly one of ten bits is set
// ---------------------------------------------------------------------------
package deci_key_pkg;

    localparam int DB_CYCLES_DEFAULT = 16;
    localparam int KEY_W             = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_PRESSED  = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_REJECT   = 3'd4
    } deci_state_t;

    // Popcount == 1 over the ten key lines.
    function automatic logic onehot10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return (n == 4'd1);
    endfunction

endpackage

// File: rtl/deci_key_debouncer_sync.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Parameterised-width two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk  in          system clock
//   rst  in          asynchronous active-high reset (both stages clear to 0)
//   d    in  WIDTH   asynchronous input vector
//   q    out WIDTH   vector synchronised to clk, two edges of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // First stage may go metastable; only the second stage is used downstream.
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/deci_key_debouncer.sv
// ---------------------------------------------------------------------------
// deci_key_debouncer
// Front-end for the decimal-to-binary encoder. Synchronises ten raw bouncing
// key lines, debounces press and release, rejects multi-key presses and
// drives a clean registered one-hot code. D is all-zero when idle, which is
// the encoder's "no digit" case.
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   key_in     in   10  raw key lines, bit n high = key n pressed
//   D          out  10  debounced one-hot key code (or all-zero)
//   key_valid  out  1   one-cycle pulse when a new press is accepted
//   key_held   out  1   high while an accepted key is held (incl. release debounce)
//   multi_err  out  1   one-cycle pulse when a debounced press is not one-hot
//   fsm_state  out  3   current FSM state, for observation
//
// Handshake: there is no backpressure. key_valid is a single-cycle strobe
// qualifying D on that cycle; D then stays stable until the release has been
// debounced. key_valid and multi_err are never high together.
// ---------------------------------------------------------------------------
module deci_key_debouncer
    import deci_key_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CW        = $clog2(DB_CYCLES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  key_in,
    output logic [9:0]  D,
    output logic        key_valid,
    output logic        key_held,
    output logic        multi_err,
    output deci_state_t fsm_state
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [9:0]    key_s;
    logic [9:0]    cand;
    logic [CW-1:0] cnt;
    deci_state_t   state;

    sync_2ff #(
        .WIDTH (KEY_W)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (key_s)
    );

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= '0;
            cnt       <= '0;
            D         <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            // Strobes default low so they are exactly one cycle wide.
            key_valid <= 1'b0;
            multi_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (key_s != 10'd0) begin
                        cand  <= key_s;
                        cnt   <= '0;
                        state <= ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (key_s == 10'd0) begin
                        state <= ST_IDLE;
                    end else if (key_s != cand) begin
                        // Pattern moved: restart the stability count on it.
                        cand <= key_s;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (onehot10(cand)) begin
                            D         <= cand;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= ST_PRESSED;
                        end else begin
                            multi_err <= 1'b1;
                            state     <= ST_REJECT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_PRESSED: begin
                    // Any change, even an extra key, starts release tracking.
                    if (key_s != cand) begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (key_s == cand) begin
                        // Short drop-out: resume without a new strobe.
                        state <= ST_PRESSED;
                    end else if (key_s == 10'd0) begin
                        if (cnt == CNT_LAST) begin
                            D        <= '0;
                            key_held <= 1'b0;
                            cnt      <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        // Some other key(s) down: wait for a full release.
                        cnt <= '0;
                    end
                end

                ST_REJECT: begin
                    // D is already zero here; only a full release leaves.
                    if (key_s == 10'd0) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end

                default: begin
                    D        <= '0;
                    key_held <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deci_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_deci_key_debouncer
// Directed bench for deci_key_debouncer with DB_CYCLES = 4 (press and release
// latency of 7 edges). Every accepted press or multi-key rejection expected
// by the stimulus is queued as {multi_err, D}; each observed strobe pops and
// compares one entry.
// ---------------------------------------------------------------------------
module tb_deci_key_debouncer;
    import deci_key_pkg::*;

    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  key_in = 10'd0;
    logic [9:0]  D;
    logic        key_valid;
    logic        key_held;
    logic        multi_err;
    deci_state_t fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [10:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    deci_key_debouncer #(
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .D         (D),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_err (multi_err),
        .fsm_state (fsm_state)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Encoder reference: index of the set bit (0 when idle).
    function automatic int enc(input logic [9:0] v);
        int y;
        y = 0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) y = i;
        end
        return y;
    endfunction

    task automatic monitor();
        check("valid_err_exclusive", 32'(key_valid & multi_err), 32'd0);
        check("d_onehot_or_zero", 32'((D == 10'd0) || onehot10(D)), 32'd1);
        if (key_valid || multi_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {21'd0, multi_err, D}, 32'd0);
            end else begin
                check("pulse_event", {21'd0, multi_err, D}, 32'(exp_q.pop_front()));
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_accept(input logic [9:0] key);
        exp_q.push_back({1'b0, key});
        ticks(LAT - 1);
        check("pre_accept_valid", 32'(key_valid), 32'd0);
        tick();
        check("accept_valid", 32'(key_valid), 32'd1);
        check("accept_D", 32'(D), 32'(key));
        check("accept_held", 32'(key_held), 32'd1);
    endtask

    task automatic press(input logic [9:0] key);
        key_in = key;
        expect_accept(key);
    endtask

    task automatic release_key(input logic [9:0] prev);
        key_in = 10'd0;
        ticks(LAT - 1);
        check("pre_release_D", 32'(D), 32'(prev));
        check("pre_release_held", 32'(key_held), 32'd1);
        tick();
        check("release_D", 32'(D), 32'd0);
        check("release_held", 32'(key_held), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0] k;

        // Reset state
        ticks(2);
        check("rst_D", 32'(D), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_multi", 32'(multi_err), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        ticks(2);

        // Clean press of key 3, held 20 cycles
        press(10'h008);
        check("clean_enc", 32'(enc(D)), 32'd3);
        ticks(13);
        check("clean_hold_D", 32'(D), 32'h008);
        release_key(10'h008);
        check("clean_enc_idle", 32'(enc(D)), 32'd0);
        ticks(3);

        // Bounce on key 0: 2-cycle phases never last long enough
        for (int p = 0; p < 5; p++) begin
            key_in = (p % 2 == 1) ? 10'h001 : 10'h000;
            ticks(2);
        end
        check("bounce_no_D", 32'(D), 32'd0);
        press(10'h001);
        release_key(10'h001);
        ticks(3);

        // Multi-key press: rejected, then a single key is accepted
        key_in = 10'h006;
        exp_q.push_back({1'b1, 10'd0});
        ticks(LAT - 1);
        check("pre_multi", 32'(multi_err), 32'd0);
        tick();
        check("multi_pulse", 32'(multi_err), 32'd1);
        check("multi_D", 32'(D), 32'd0);
        check("multi_held", 32'(key_held), 32'd0);
        check("multi_state", 32'(fsm_state), 32'(ST_REJECT));
        ticks(10);
        check("multi_hold_D", 32'(D), 32'd0);
        key_in = 10'd0;
        ticks(LAT + 2);
        check("multi_back_idle", 32'(fsm_state), 32'(ST_IDLE));
        press(10'h020);
        release_key(10'h020);
        ticks(3);

        // Release glitch on key 9
        press(10'h200);
        key_in = 10'd0;
        ticks(2);
        key_in = 10'h200;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_hold_D", 32'(D), 32'h200);
        end
        check("glitch_state", 32'(fsm_state), 32'(ST_PRESSED));
        release_key(10'h200);
        ticks(3);

        // Reset mid-PRESSED with key 5 still held
        press(10'h020);
        ticks(3);
        #1 rst = 1'b1;
        #1;
        check("midrst_D", 32'(D), 32'd0);
        check("midrst_held", 32'(key_held), 32'd0);
        check("midrst_valid", 32'(key_valid), 32'd0);
        tick();
        rst = 1'b0;
        expect_accept(10'h020);
        release_key(10'h020);
        ticks(3);

        // All digits 0..9
        for (int d = 0; d < 10; d++) begin
            k = 10'd1 << d;
            press(k);
            check("digit_enc", 32'(enc(D)), 32'(d));
            ticks(3);
            release_key(k);
            ticks(3);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
